// File: rtl/select_scanner.sv
// Slot sequencer for the mux4/decoder stage: steps {sel0,sel1} through enabled slots, DIV clocks each.
// Optional SCAN_DIR_EN adds a dir input for downward scanning.
module select_scanner #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  input  logic       load,
  input  logic [1:0] load_sel,
  input  logic [3:0] mask,
`ifdef SCAN_DIR_EN
  input  logic       dir,
`endif
  output logic       sel0,
  output logic       sel1,
  output logic       slot_start,
  output logic       wrap,
  output logic       idle
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;
  logic [1:0] sel;
  logic [1:0] nxt;
  logic [1:0] cand;
  logic       found;
  logic       nxt_wrap;
  logic       down;

`ifdef SCAN_DIR_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // Search order ends at the current slot itself, so a lone enabled slot re-selects itself.
  always_comb begin
    nxt   = sel;
    cand  = sel;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = down ? (sel - 2'(k)) : (sel + 2'(k));
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    nxt_wrap = down ? (nxt >= sel) : (nxt <= sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= 2'd0;
      cnt        <= 8'd0;
      slot_start <= 1'b0;
      wrap       <= 1'b0;
      idle       <= (mask == 4'b0000);
    end else if (load) begin
      sel        <= load_sel;
      cnt        <= 8'd0;
      slot_start <= 1'b1;
      wrap       <= 1'b0;
      idle       <= (mask == 4'b0000);
    end else if (hold) begin
      slot_start <= 1'b0;
      wrap       <= 1'b0;
    end else if (!en) begin
      cnt        <= 8'd0;
      slot_start <= 1'b0;
      wrap       <= 1'b0;
      idle       <= (mask == 4'b0000);
    end else begin
      idle       <= (mask == 4'b0000);
      slot_start <= 1'b0;
      wrap       <= 1'b0;
      if (cnt == LAST) begin
        cnt <= 8'd0;
        // With no slot enabled the boundary passes silently and sel stays put.
        if (found) begin
          sel        <= nxt;
          slot_start <= 1'b1;
          wrap       <= nxt_wrap;
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign sel0 = sel[1];
  assign sel1 = sel[0];

endmodule

// File: tb/tb_select_scanner.sv
// Bench for select_scanner: DIV=4 and DIV=1 instances driven in parallel, checked per cycle
// against a slot-level reference model through expected-output queues.
module tb_select_scanner;

  logic       clk = 1'b0;
  logic       rst, en, hold, load, dir;
  logic [1:0] load_sel;
  logic [3:0] mask;

  logic sel0_a, sel1_a, ss_a, wrap_a, idle_a;
  logic sel0_b, sel1_b, ss_b, wrap_b, idle_b;

  int checks = 0;
  int passed = 0;

  // Expected {sel0,sel1,slot_start,wrap,idle} after each rising edge.
  logic [4:0] exp_qa[$];
  logic [4:0] exp_qb[$];

  int m_slot[2];
  int m_cnt[2];
  bit m_ss[2], m_wr[2], m_idle[2];
  int div_of[2] = '{4, 1};

  always #5 clk = ~clk;

  select_scanner #(.DIV(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .load(load),
    .load_sel(load_sel), .mask(mask),
`ifdef SCAN_DIR_EN
    .dir(dir),
`endif
    .sel0(sel0_a), .sel1(sel1_a), .slot_start(ss_a), .wrap(wrap_a), .idle(idle_a)
  );

  select_scanner #(.DIV(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .load(load),
    .load_sel(load_sel), .mask(mask),
`ifdef SCAN_DIR_EN
    .dir(dir),
`endif
    .sel0(sel0_b), .sel1(sel1_b), .slot_start(ss_b), .wrap(wrap_b), .idle(idle_b)
  );

  function automatic int next_slot(int s, logic [3:0] m, logic d);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = d ? (s - k + 8) % 4 : (s + k) % 4;
      if (m[c]) return c;
    end
    return s;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [4:0] e;
      if (rst) begin
        m_slot[i] = 0; m_cnt[i] = 0; m_ss[i] = 0; m_wr[i] = 0; m_idle[i] = (mask == 0);
      end else if (load) begin
        m_slot[i] = load_sel; m_cnt[i] = 0; m_ss[i] = 1; m_wr[i] = 0; m_idle[i] = (mask == 0);
      end else if (hold) begin
        m_ss[i] = 0; m_wr[i] = 0;
      end else if (!en) begin
        m_cnt[i] = 0; m_ss[i] = 0; m_wr[i] = 0; m_idle[i] = (mask == 0);
      end else begin
        m_idle[i] = (mask == 0);
        m_ss[i] = 0; m_wr[i] = 0;
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == div_of[i]) begin
          m_cnt[i] = 0;
          if (mask != 0) begin
            int n;
            n = next_slot(m_slot[i], mask, dir);
            m_wr[i] = dir ? (n >= m_slot[i]) : (n <= m_slot[i]);
            m_slot[i] = n;
            m_ss[i] = 1;
          end
        end
      end
      e = {m_slot[i][1], m_slot[i][0], m_ss[i], m_wr[i], m_idle[i]};
      if (i == 0) exp_qa.push_back(e);
      else exp_qb.push_back(e);
    end
  endtask

  task automatic step(int n = 1);
    for (int j = 0; j < n; j++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  // Monitor: one output word per instance per edge.
  always @(posedge clk) begin
    logic [4:0] e, got;
    #1;
    if (exp_qa.size() > 0) begin
      e = exp_qa.pop_front();
      got = {sel0_a, sel1_a, ss_a, wrap_a, idle_a};
      checks++;
      if (got === e) passed++;
      else $display("FAIL div4 {sel0,sel1,slot_start,wrap,idle} got %b exp %b at %0t", got, e, $time);
    end
    if (exp_qb.size() > 0) begin
      e = exp_qb.pop_front();
      got = {sel0_b, sel1_b, ss_b, wrap_b, idle_b};
      checks++;
      if (got === e) passed++;
      else $display("FAIL div1 {sel0,sel1,slot_start,wrap,idle} got %b exp %b at %0t", got, e, $time);
    end
  end

  initial begin
    rst = 1; en = 0; hold = 0; load = 0; load_sel = 0; mask = 4'hF; dir = 0;
    // Reset, then free-running full scan
    step(2);
    rst = 0; en = 1;
    step(20);
    // Sparse mask starting from slot 1
    load = 1; load_sel = 2'd1; mask = 4'b1010;
    step(1);
    load = 0;
    step(16);
    // Hold mid-slot at cnt=2
    mask = 4'hF; load = 1; load_sel = 2'd0;
    step(1);
    load = 0;
    step(2);
    hold = 1;
    step(5);
    hold = 0;
    step(4);
    // Load wins over hold and en=0
    load = 1; load_sel = 2'd2; hold = 1; en = 0;
    step(1);
    load = 0;
    step(3);
    hold = 0; en = 1;
    step(3);
    // Reset wins over load
    rst = 1; load = 1; load_sel = 2'd3;
    step(1);
    rst = 0; load = 0;
    step(3);
    // Empty mask, then a single enabled slot
    load = 1; load_sel = 2'd3;
    step(1);
    load = 0; mask = 4'b0000;
    step(10);
    mask = 4'b0001;
    step(10);
    // Only the current slot enabled
    mask = 4'b0100; load = 1; load_sel = 2'd2;
    step(1);
    load = 0;
    step(10);
    // Enable dropped mid-slot clears the count
    mask = 4'hF;
    step(2);
    en = 0;
    step(2);
    en = 1;
    step(6);
`ifdef SCAN_DIR_EN
    dir = 1; load = 1; load_sel = 2'd0;
    step(1);
    load = 0;
    step(12);
    dir = 0;
`endif
    // Randomized phase
    for (int r = 0; r < 600; r++) begin
      rst      = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 99) < 6);
      load_sel = 2'($urandom_range(0, 3));
      hold     = ($urandom_range(0, 99) < 10);
      en       = ($urandom_range(0, 99) < 90);
      if ($urandom_range(0, 99) < 5) mask = 4'($urandom_range(0, 15));
`ifdef SCAN_DIR_EN
      if ($urandom_range(0, 99) < 5) dir = 1'($urandom_range(0, 1));
`endif
      step(1);
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_qa.size() == 0 && exp_qb.size() == 0) passed++;
    else $display("FAIL drain queues left %0d/%0d exp 0/0", exp_qa.size(), exp_qb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
